conv_addr_gen: RTL
==================

Name: conv_addr_gen

Overview:
- Compute-phase address sequencer. Sits directly downstream of the layer control unit.
- Starts on that unit's cal_start level. Walks the convolution loop nest over the configured IFM, weight and OFM geometry.
- Issues one IFM buffer address and one weight buffer address per beat to the PE array over a valid/ready handshake.
- Returns done_compute to the control unit when the whole layer has been sequenced and the PE pipeline has drained.

Parameters:
TOTAL_PE, 16, output channels computed in parallel per tile (one filter per PE)
ADDR_W, 32, width of ifm_addr and weight_addr (element-indexed)
DRAIN_CYCLES, 4, cycles waited after the last accepted beat for PE pipeline flush (0 is legal)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cal_start  in  1  level: compute requested; deassertion aborts or acknowledges done
KERNEL_W  in  4  kernel width/height (square)
OFM_W  in  8  output feature map width/height
OFM_C  in  8  output channels
IFM_C  in  8  input channels
IFM_W  in  8  input feature map width/height
stride  in  2  convolution stride; 0 treated as 1
addr_ready  in  1  PE array accepts current beat
addr_valid  out  1  ifm_addr/weight_addr valid
ifm_addr  out  ADDR_W  ((oy*s+ky)*IFM_W + ox*s+kx)*IFM_C + c
weight_addr  out  ADDR_W  t*KW*KW*IFM_C + (ky*KW+kx)*IFM_C + c
window_last  out  1  beat is the final MAC of one output pixel (ky,kx,c all at max)
tile_last  out  1  window_last and last pixel of current channel tile
done_compute  out  1  layer sequencing complete

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset mid-operation discards progress. No beat is issued until a new cal_start rising is seen in IDLE.
- Geometry is latched when IDLE sees cal_start=1. Input changes during RUN are ignored.
- Derived values: s = (stride==0)?1:stride; NT = ceil(OFM_C/TOTAL_PE).
- Loop order, outer to inner: t (0..NT-1), oy, ox (0..OFM_W-1), ky, kx (0..KW-1), c (0..IFM_C-1).
- Arithmetic is unsigned, computed at ADDR_W and truncated. Incremental adders are preferred over per-beat multipliers, but the formulas above are normative.
- States:
  - IDLE: cal_start=1 with all of KW, OFM_W, IFM_C, OFM_C nonzero -> RUN. addr_valid rises on the next cycle, so first-beat latency is 1 cycle. cal_start=1 with any of them zero -> DONE directly, with no beats issued.
  - RUN: addr_valid=1. A beat completes on addr_valid & addr_ready, and counters advance that cycle. With addr_valid=1 and addr_ready=0, all outputs hold stable. The last beat's handshake -> DRAIN, or -> DONE if DRAIN_CYCLES=0. A full-rate stream is supported with no bubbles.
  - DRAIN: addr_valid=0. Counts DRAIN_CYCLES cycles, then -> DONE.
  - DONE: done_compute=1, held as a level until cal_start=0, then -> IDLE with done_compute=0 on the next cycle.
- Abort: cal_start=0 in RUN or DRAIN -> IDLE next cycle, addr_valid=0, counters cleared, no done_compute.
- window_last and tile_last are combinational from the counters, qualified by addr_valid.
- Wrap: c wraps to 0 and increments kx; then ky; then ox; then oy; then t. The last beat is every counter at its max.
- cal_start in IDLE while still high after an abort-free DONE cannot occur: DONE waits for it to drop.

Decomposition:
- Shared package holds:
  - state encodings S_IDLE / S_RUN / S_DRAIN / S_DONE
  - the stride-0-as-1 rule as a function
  - the ceil-divide function for NT
- One natural sub-module: conv_loop_counter. It is a nested wrap counter with per-level max inputs, an advance input, and per-level last flags. It is instantiated once with six levels.
- Address accumulation stays in the top level.

Test Plan:
- KW=1, IFM_W=OFM_W=2, IFM_C=4, OFM_C=16, s=1, addr_ready=1:
  - 16 beats; ifm_addr 0..15; weight_addr 0,1,2,3 repeating.
  - window_last on beats 3, 7, 11, 15; tile_last on beat 15.
  - done_compute rises 1+DRAIN_CYCLES cycles after the last beat.
- KW=3, IFM_W=5, OFM_W=2, IFM_C=1, OFM_C=1, stride=2:
  - pixel (0,0) ifm_addr 0,1,2,5,6,7,10,11,12; pixel (0,1) starts at 2.
  - 36 beats total; weight_addr 0..8 repeating.
- OFM_C=32, KW=1, IFM_C=2, OFM_W=IFM_W=1:
  - NT=2; weight_addr 0,1 then 2,3; tile_last on beats 1 and 3.
- Backpressure: toggle addr_ready pseudo-randomly on scenario 1.
  - Outputs stable while stalled; identical accepted sequence; no lost or duplicated beats.
- Abort and restart:
  - Drop cal_start after beat 5 -> addr_valid=0 next cycle, no done_compute.
  - Reassert -> sequence restarts at ifm_addr 0.
  - Separately, assert rst_n=0 mid-RUN -> all outputs 0 immediately.
- Zero geometry (IFM_C=0) with cal_start=1 -> no addr_valid, done_compute=1 on the next cycle, cleared one cycle after cal_start=0.

Source files
------------

// File: rtl/conv_addr_gen_pkg.sv
// conv_addr_gen_pkg: shared types and helpers for the compute-phase address sequencer.
//   state_e     - sequencer FSM encodings
//   NUM_LEVELS  - depth of the convolution loop nest (t, oy, ox, ky, kx, c)
//   CNT_W       - width of each loop counter level
//   LVL_*       - loop-nest level indices, innermost (c) first
//   eff_stride  - stride with 0 treated as 1
//   ceil_div    - ceiling division, used for the channel-tile count
package conv_addr_gen_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam int unsigned NUM_LEVELS = 6;
    localparam int unsigned CNT_W      = 8;

    localparam int unsigned LVL_C  = 0;
    localparam int unsigned LVL_KX = 1;
    localparam int unsigned LVL_KY = 2;
    localparam int unsigned LVL_OX = 3;
    localparam int unsigned LVL_OY = 4;
    localparam int unsigned LVL_T  = 5;

    function automatic logic [1:0] eff_stride(input logic [1:0] stride);
        return (stride == 2'd0) ? 2'd1 : stride;
    endfunction

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/conv_addr_gen_if.sv
// conv_addr_gen_if: address stream from the sequencer to the PE array.
//   addr_valid  - beat valid (sequencer -> PE array)
//   addr_ready  - PE array accepts the current beat
//   ifm_addr    - IFM buffer element address
//   weight_addr - weight buffer element address
//   window_last - final MAC of one output pixel
//   tile_last   - final MAC of the last pixel of a channel tile
// master: sequencer side; slave: PE array side.
interface conv_addr_gen_if #(
    parameter int unsigned ADDR_W = 32
);

    logic              addr_valid;
    logic              addr_ready;
    logic [ADDR_W-1:0] ifm_addr;
    logic [ADDR_W-1:0] weight_addr;
    logic              window_last;
    logic              tile_last;

    modport master (
        output addr_valid,
        output ifm_addr,
        output weight_addr,
        output window_last,
        output tile_last,
        input  addr_ready
    );

    modport slave (
        input  addr_valid,
        input  ifm_addr,
        input  weight_addr,
        input  window_last,
        input  tile_last,
        output addr_ready
    );

endinterface

// File: rtl/conv_loop_counter.sv
// conv_loop_counter: nested wrap counter. Level 0 is innermost; a level steps when advance is
// high and every lower level sits at its max, wrapping to 0 when it is itself at max.
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - synchronous clear of all levels (wins over advance)
//   advance    - step the innermost level
//   max_val    - per-level terminal count (inclusive)
//   last       - per-level "counter equals max" flags
//   all_last   - every level at its max
module conv_loop_counter #(
    parameter int unsigned LEVELS = 6,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           advance,
    input  logic [LEVELS-1:0][CNT_W-1:0]   max_val,
    output logic [LEVELS-1:0]              last,
    output logic                           all_last
);

    logic [LEVELS-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        last = '0;
        for (int i = 0; i < LEVELS; i++) begin
            last[i] = (cnt_q[i] == max_val[i]);
        end
        all_last = &last;
    end

    always_comb begin
        logic carry;
        carry = advance;
        cnt_d = cnt_q;
        for (int i = 0; i < LEVELS; i++) begin
            if (clear) begin
                cnt_d[i] = '0;
            end else if (carry) begin
                cnt_d[i] = last[i] ? '0 : cnt_q[i] + CNT_W'(1);
            end
            // Carry ripples outward only through levels that are wrapping.
            carry = carry & last[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: compute-phase address sequencer. On cal_start it latches the layer geometry
// and walks t / oy / ox / ky / kx / c, issuing one IFM and one weight address per beat on a
// valid/ready stream, then waits DRAIN_CYCLES for the PE pipeline before raising done_compute.
//   clk, rst_n          - clock, asynchronous active-low reset
//   cal_start           - compute request level; dropping it aborts or acknowledges done
//   KERNEL_W            - square kernel size
//   OFM_W, OFM_C        - output map width/height and channel count
//   IFM_C, IFM_W        - input channel count and input map width/height
//   stride              - convolution stride (0 behaves as 1)
//   addr_bus            - address stream to the PE array (master side)
//   done_compute        - layer fully sequenced and drained, held until cal_start drops
module conv_addr_gen
    import conv_addr_gen_pkg::*;
#(
    parameter int unsigned TOTAL_PE     = 16,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cal_start,
    input  logic [3:0]             KERNEL_W,
    input  logic [7:0]             OFM_W,
    input  logic [7:0]             OFM_C,
    input  logic [7:0]             IFM_C,
    input  logic [7:0]             IFM_W,
    input  logic [1:0]             stride,
    conv_addr_gen_if.master        addr_bus,
    output logic                   done_compute
);

    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 2);

    state_e                          state_q, state_d;
    logic [DRAIN_W-1:0]              drain_q, drain_d;
    logic [NUM_LEVELS-1:0][CNT_W-1:0] max_q;

    // Per-layer address strides, computed once when the geometry is latched.
    logic [ADDR_W-1:0] row_step_q;   // IFM_W*IFM_C       : next kernel row
    logic [ADDR_W-1:0] ox_step_q;    // s*IFM_C           : next output column
    logic [ADDR_W-1:0] oy_step_q;    // s*IFM_W*IFM_C     : next output row
    logic [ADDR_W-1:0] filt_step_q;  // KW*KW*IFM_C       : next channel tile

    // Running bases: row_base at (oy,0), pix_base at (oy,ox), ky_base at (oy,ox,ky).
    logic [ADDR_W-1:0] tile_base_q, tile_base_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] pix_base_q, pix_base_d;
    logic [ADDR_W-1:0] ky_base_q, ky_base_d;
    logic [ADDR_W-1:0] ifm_q, ifm_d;
    logic [ADDR_W-1:0] wgt_q, wgt_d;

    logic                  start, geom_ok, fire, run_next, valid;
    logic [NUM_LEVELS-1:0] last;
    logic                  all_last;
    logic                  kxc_end, win_end, row_end, tile_end;

    logic [1:0]        s_eff;
    logic [ADDR_W-1:0] s_a, kw_a, ifm_w_a, ifm_c_a;

    assign s_eff   = eff_stride(stride);
    assign s_a     = ADDR_W'(s_eff);
    assign kw_a    = ADDR_W'(KERNEL_W);
    assign ifm_w_a = ADDR_W'(IFM_W);
    assign ifm_c_a = ADDR_W'(IFM_C);

    assign geom_ok  = (KERNEL_W != 4'd0) && (OFM_W != 8'd0) && (IFM_C != 8'd0)
                    && (OFM_C != 8'd0);
    assign start    = (state_q == S_IDLE) && cal_start;
    assign valid    = (state_q == S_RUN);
    assign fire     = valid && addr_bus.addr_ready;
    assign run_next = (state_d == S_RUN);

    // kx and c together form one contiguous run of KW*IFM_C addresses.
    assign kxc_end  = last[LVL_C] & last[LVL_KX];
    assign win_end  = kxc_end & last[LVL_KY];
    assign row_end  = win_end & last[LVL_OX];
    assign tile_end = row_end & last[LVL_OY];

    // Geometry latch; input changes outside IDLE are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q       <= '0;
            row_step_q  <= '0;
            ox_step_q   <= '0;
            oy_step_q   <= '0;
            filt_step_q <= '0;
        end else if (start) begin
            max_q[LVL_C]  <= CNT_W'(IFM_C) - CNT_W'(1);
            max_q[LVL_KX] <= CNT_W'(KERNEL_W) - CNT_W'(1);
            max_q[LVL_KY] <= CNT_W'(KERNEL_W) - CNT_W'(1);
            max_q[LVL_OX] <= CNT_W'(OFM_W) - CNT_W'(1);
            max_q[LVL_OY] <= CNT_W'(OFM_W) - CNT_W'(1);
            max_q[LVL_T]  <= CNT_W'(ceil_div(32'(OFM_C), TOTAL_PE) - 1);
            row_step_q    <= ifm_w_a * ifm_c_a;
            ox_step_q     <= s_a * ifm_c_a;
            oy_step_q     <= s_a * ifm_w_a * ifm_c_a;
            filt_step_q   <= kw_a * kw_a * ifm_c_a;
        end
    end

    conv_loop_counter #(
        .LEVELS (NUM_LEVELS),
        .CNT_W  (CNT_W)
    ) u_loop_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!run_next),
        .advance  (fire),
        .max_val  (max_q),
        .last     (last),
        .all_last (all_last)
    );

    always_comb begin
        state_d = state_q;
        drain_d = '0;
        unique case (state_q)
            S_IDLE: begin
                if (cal_start) begin
                    state_d = geom_ok ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (!cal_start) begin
                    state_d = S_IDLE;
                end else if (fire && all_last) begin
                    state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!cal_start) begin
                    state_d = S_IDLE;
                end else if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            S_DONE: begin
                if (!cal_start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Incremental address update: every step is a single add onto a held base.
    always_comb begin
        tile_base_d = tile_base_q;
        row_base_d  = row_base_q;
        pix_base_d  = pix_base_q;
        ky_base_d   = ky_base_q;
        ifm_d       = ifm_q;
        wgt_d       = wgt_q;
        if (!run_next) begin
            tile_base_d = '0;
            row_base_d  = '0;
            pix_base_d  = '0;
            ky_base_d   = '0;
            ifm_d       = '0;
            wgt_d       = '0;
        end else if (fire) begin
            if (tile_end) begin
                tile_base_d = tile_base_q + filt_step_q;
                row_base_d  = '0;
                pix_base_d  = '0;
                ky_base_d   = '0;
                ifm_d       = '0;
                wgt_d       = tile_base_q + filt_step_q;
            end else if (row_end) begin
                row_base_d  = row_base_q + oy_step_q;
                pix_base_d  = row_base_q + oy_step_q;
                ky_base_d   = row_base_q + oy_step_q;
                ifm_d       = row_base_q + oy_step_q;
                wgt_d       = tile_base_q;
            end else if (win_end) begin
                pix_base_d  = pix_base_q + ox_step_q;
                ky_base_d   = pix_base_q + ox_step_q;
                ifm_d       = pix_base_q + ox_step_q;
                wgt_d       = tile_base_q;
            end else if (kxc_end) begin
                ky_base_d   = ky_base_q + row_step_q;
                ifm_d       = ky_base_q + row_step_q;
                wgt_d       = wgt_q + ADDR_W'(1);
            end else begin
                ifm_d       = ifm_q + ADDR_W'(1);
                wgt_d       = wgt_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            drain_q     <= '0;
            tile_base_q <= '0;
            row_base_q  <= '0;
            pix_base_q  <= '0;
            ky_base_q   <= '0;
            ifm_q       <= '0;
            wgt_q       <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            tile_base_q <= tile_base_d;
            row_base_q  <= row_base_d;
            pix_base_q  <= pix_base_d;
            ky_base_q   <= ky_base_d;
            ifm_q       <= ifm_d;
            wgt_q       <= wgt_d;
        end
    end

    assign addr_bus.addr_valid  = valid;
    assign addr_bus.ifm_addr    = ifm_q;
    assign addr_bus.weight_addr = wgt_q;
    assign addr_bus.window_last = valid & win_end;
    assign addr_bus.tile_last   = valid & tile_end;
    assign done_compute         = (state_q == S_DONE);

endmodule
